// File: rtl/hex_mem_pkg.sv
// Shared definitions for the memory responder: I/O window layout, FSM states and
// the address-region decoder used by both the commit path and the read path.
package hex_mem_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
  localparam int unsigned IO_OUT_OFS      = 0;
  localparam int unsigned IO_IN_OFS       = 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } mem_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO_OUT,
    REG_IO_IN,
    REG_UNMAPPED
  } region_t;

  // Arguments are zero-extended to 32 bits so one decoder serves any ADDR_W.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_depth,
                                            input logic [31:0] io_base);
    if (addr < ram_depth) begin
      return REG_RAM;
    end else if (addr == io_base + 32'(IO_OUT_OFS)) begin
      return REG_IO_OUT;
    end else if (addr == io_base + 32'(IO_IN_OFS)) begin
      return REG_IO_IN;
    end else begin
      return REG_UNMAPPED;
    end
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: registered read, read-old-data on a same-cycle write.
// Contents are deliberately not reset.
module sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: decodes each request to data RAM or the two-register I/O
// window, performs the access and returns readdata with a one-cycle memready pulse.
module mem_responder
  import hex_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       RAM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              memready,
  output logic              memerr,
  output logic [DATA_W-1:0] io_out,
  input  logic [DATA_W-1:0] io_in
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

  mem_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] io_in_meta;
  logic [DATA_W-1:0] io_in_sync;
  logic [DATA_W-1:0] ram_rdata;
  region_t           req_region;
  region_t           rd_region;
  logic              idle_write;
  logic              ram_we;

  // Writes commit on the sampling edge, so the live address is decoded; reads use addr_q.
  always_comb begin
    req_region = decode_region(32'(addr), 32'(RAM_DEPTH), 32'(IO_BASE));
    rd_region  = decode_region(32'(addr_q), 32'(RAM_DEPTH), 32'(IO_BASE));
    idle_write = (state == IDLE) && memwrite && !memread;
    ram_we     = idle_write && (req_region == REG_RAM);
  end

  // Read address is presented in IDLE so the registered RAM output is valid in RD_WAIT.
  sp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr[RAM_AW-1:0]),
    .wdata(writedata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_in_meta <= '0;
      io_in_sync <= '0;
    end else begin
      io_in_meta <= io_in;
      io_in_sync <= io_in_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      readdata <= '0;
      memready <= 1'b0;
      memerr   <= 1'b0;
      io_out   <= '0;
    end else begin
      memready <= 1'b0;
      memerr   <= 1'b0;
      unique case (state)
        IDLE: begin
          addr_q <= addr;
          if (memread && memwrite) begin
            memready <= 1'b1;
            memerr   <= 1'b1;
            state    <= RESP;
          end else if (memwrite) begin
            if (req_region == REG_IO_OUT) begin
              io_out <= writedata;
            end
            memready <= 1'b1;
            memerr   <= (req_region == REG_UNMAPPED);
            state    <= RESP;
          end else if (memread) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          unique case (rd_region)
            REG_RAM:    readdata <= ram_rdata;
            REG_IO_OUT: readdata <= io_out;
            REG_IO_IN:  readdata <= io_in_sync;
            default: begin
              readdata <= '0;
              memerr   <= 1'b1;
            end
          endcase
          memready <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
